// File: rtl/s100_bus_cycle_seq.sv
// S-100 bus-cycle sequencer: runs one CPU memory/I/O request as a T1/T2/TW/T3 cycle with registered bus outputs.
// Optional macro S100_XRDY_EN: when defined, xrdy = 0 stretches the cycle in TW; otherwise xrdy is ignored.
module s100_bus_cycle_seq #(
    parameter int WAIT_STATES    = 1,
    parameter int IO_WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_io,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [15:0] bus_adr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    input  logic        xrdy,
    output logic        sMEMR,
    output logic        sINP,
    output logic        sOUT,
    output logic        sWO_n,
    output logic        pSYNC,
    output logic        pDBIN,
    output logic        pWR_n
);

    localparam logic [2:0] MEM_CNT = 3'(WAIT_STATES);
    localparam logic [2:0] IO_CNT  = 3'(IO_WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        io_q, io_d;
    logic [15:0] bus_adr_q, bus_adr_d;
    logic [7:0]  bus_dout_q, bus_dout_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        smemr_q, smemr_d;
    logic        sinp_q, sinp_d;
    logic        sout_q, sout_d;
    logic        swo_n_q, swo_n_d;
    logic        psync_q, psync_d;
    logic        pdbin_q, pdbin_d;
    logic        pwr_n_q, pwr_n_d;
    logic        stall_s;
    logic        in_cycle_s;
    logic        strobe_s;

`ifdef S100_XRDY_EN
    assign stall_s = ~xrdy;
`else
    logic unused_xrdy_s;
    assign unused_xrdy_s = xrdy;
    assign stall_s       = 1'b0;
`endif

    // Next state, request capture, and outputs derived from the state being entered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        io_d       = io_q;
        bus_adr_d  = bus_adr_q;
        bus_dout_d = bus_dout_q;
        cpu_din_d  = cpu_din_q;
        in_cycle_s = 1'b0;
        strobe_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d    = ST_T1;
                    wr_d       = cpu_wr;
                    io_d       = cpu_io;
                    bus_adr_d  = cpu_io ? {8'h00, cpu_adr[7:0]} : cpu_adr;
                    bus_dout_d = cpu_dout;
                    cnt_d      = cpu_io ? IO_CNT : MEM_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T1: begin
                state_d = ST_T2;
            end
            ST_T2, ST_TW: begin
                // The count is spent on entry to each TW, so T3 follows once it reaches zero unstalled
                if (cnt_q != 3'd0) begin
                    state_d = ST_TW;
                    cnt_d   = cnt_q - 3'd1;
                end else if (stall_s) begin
                    state_d = ST_TW;
                end else begin
                    state_d = ST_T3;
                    if (!wr_q) begin
                        cpu_din_d = bus_din;
                    end else begin
                        cpu_din_d = cpu_din_q;
                    end
                end
            end
            ST_T3: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_cycle_s = (state_d != ST_IDLE);
        strobe_s   = (state_d == ST_T2) || (state_d == ST_TW);
        smemr_d    = in_cycle_s & ~io_d & ~wr_d;
        sinp_d     = in_cycle_s &  io_d & ~wr_d;
        sout_d     = in_cycle_s &  io_d &  wr_d;
        swo_n_d    = ~(in_cycle_s & wr_d);
        psync_d    = (state_d == ST_T1);
        pdbin_d    = strobe_s & ~wr_d;
        pwr_n_d    = ~(strobe_s & wr_d);
        cpu_ack_d  = (state_d == ST_T3);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            io_q       <= 1'b0;
            bus_adr_q  <= 16'h0000;
            bus_dout_q <= 8'h00;
            cpu_din_q  <= 8'h00;
            cpu_ack_q  <= 1'b0;
            smemr_q    <= 1'b0;
            sinp_q     <= 1'b0;
            sout_q     <= 1'b0;
            swo_n_q    <= 1'b1;
            psync_q    <= 1'b0;
            pdbin_q    <= 1'b0;
            pwr_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            io_q       <= io_d;
            bus_adr_q  <= bus_adr_d;
            bus_dout_q <= bus_dout_d;
            cpu_din_q  <= cpu_din_d;
            cpu_ack_q  <= cpu_ack_d;
            smemr_q    <= smemr_d;
            sinp_q     <= sinp_d;
            sout_q     <= sout_d;
            swo_n_q    <= swo_n_d;
            psync_q    <= psync_d;
            pdbin_q    <= pdbin_d;
            pwr_n_q    <= pwr_n_d;
        end
    end

    assign cpu_din  = cpu_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign bus_adr  = bus_adr_q;
    assign bus_dout = bus_dout_q;
    assign sMEMR    = smemr_q;
    assign sINP     = sinp_q;
    assign sOUT     = sout_q;
    assign sWO_n    = swo_n_q;
    assign pSYNC    = psync_q;
    assign pDBIN    = pdbin_q;
    assign pWR_n    = pwr_n_q;

endmodule

// File: doc/s100_bus_cycle_seq.md
# s100_bus_cycle_seq

Bus-cycle sequencer between the soft CPU core and the external S-100 bus on the T35 SBC. It accepts one memory or I/O request at a time and runs it as a fixed T1/T2/TW/T3 cycle. It drives the registered address, the status lines (sMEMR, sINP, sOUT, sWO_n) and the strobes (pSYNC, pDBIN, pWR_n), then returns read data with a one-cycle acknowledge. During I/O cycles it zeroes the high address byte, so the CPU never places a stray high address on the bus.

## Interface
- WAIT_STATES, 1, number of TW cycles for memory cycles (0..7).
- IO_WAIT_STATES, 2, number of TW cycles for I/O cycles (0..7).

- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_wr  in  1  1 = write, 0 = read; captured with cpu_req.
- cpu_io  in  1  1 = I/O cycle, 0 = memory cycle; captured with cpu_req.
- cpu_adr  in  16  CPU address; captured with cpu_req.
- cpu_dout  in  8  write data; captured with cpu_req.
- cpu_din  out  8  read data; valid while cpu_ack = 1 and held until the next read completes.
- cpu_ack  out  1  one-cycle pulse in T3.
- bus_adr  out  16  registered bus address; high byte forced to 0x00 when cpu_io = 1.
- bus_dout  out  8  registered write data.
- bus_din  in  8  bus read data.
- xrdy  in  1  external ready; 1 = ready.
- sMEMR, sINP, sOUT  out  1 each  status lines: memory read, I/O input, I/O output.
- sWO_n  out  1  status write, active low.
- pSYNC  out  1  high during T1 only.
- pDBIN  out  1  read strobe.
- pWR_n  out  1  write strobe, active low.

## Operation
States and transitions:
- IDLE -> T1 when cpu_req = 1.
  - Capture cpu_wr, cpu_io, cpu_adr and cpu_dout.
  - Load the wait counter with WAIT_STATES or IO_WAIT_STATES.
- T1 -> T2, unconditionally.
- T2 -> TW when counter ≠ 0 or stall; otherwise T2 -> T3.
- TW: decrement the counter each cycle. TW -> T3 when counter = 0 and no stall.
- T3 -> IDLE, unconditionally. A request present in T3 is ignored until IDLE.

Per-state outputs:
- T1: bus_adr, bus_dout and the status lines become valid; pSYNC = 1.
- Status lines are held from T1 through T3.
  - sMEMR = !io & !wr; sINP = io & !wr; sOUT = io & wr; sWO_n = !wr.
- pDBIN = 1 during T2 and TW of reads.
- pWR_n = 0 during T2 and TW of writes.
- Read data: bus_din is sampled on the edge that leaves T2/TW for T3. cpu_din is registered and presented in T3 with cpu_ack.
- IDLE: status lines and strobes are inactive. bus_adr and bus_dout hold their last values.

Captured request fields are frozen for the whole cycle; changes on cpu_* after capture have no effect.

## Timing
- Request sampled in IDLE at cycle n: T1 at n+1, T2 at n+2, cpu_ack at n+3+W (W = applicable wait count, no stall).
- Minimum access period is 4+W cycles, because IDLE is mandatory between cycles.
- Reset value of every output:
  - bus_adr = 0, bus_dout = 0, cpu_din = 0.
  - cpu_ack = 0, pSYNC = 0, pDBIN = 0.
  - sMEMR = 0, sINP = 0, sOUT = 0.
  - sWO_n = 1, pWR_n = 1.
- Reset in any state: IDLE and the reset values appear at the next edge. No cpu_ack is issued for the aborted cycle.
- W = 0: T2 goes straight to T3 unless xrdy stalls the cycle.

## Configuration
- S100_XRDY_EN defined: the stall condition is xrdy = 0, sampled in T2 and TW.
  - The cycle stays in TW with strobes active until xrdy = 1 and the counter is 0.
  - There is no timeout.
- S100_XRDY_EN undefined: xrdy is ignored (the port remains). Cycle length is fixed at 4+W.

## Test plan
- Memory read, adr 0x1234, WAIT_STATES = 1, bus_din = 0xA5, req at n:
  - pSYNC high at n+1 only; sMEMR high n+1..n+4; pDBIN high n+2..n+3.
  - bus_adr = 0x1234; cpu_ack at n+4 with cpu_din = 0xA5.
- I/O output, adr 0x12F0, data 0x3C, IO_WAIT_STATES = 2:
  - bus_adr = 0x00F0, bus_dout = 0x3C, sOUT = 1, sWO_n = 0.
  - pWR_n low for 3 cycles; cpu_ack at n+5.
- I/O input, adr 0xFF10: bus_adr = 0x0010, sINP = 1, sMEMR = 0, pDBIN high in T2/TW.
- Memory write with xrdy held low for 4 cycles from T2:
  - With S100_XRDY_EN, pWR_n stays low until xrdy rises and cpu_ack follows one cycle later.
  - Without it, cpu_ack arrives at n+4 regardless of xrdy.
- Reset asserted in TW: at the next edge all outputs take their reset values and cpu_ack never pulses. A following read completes normally.
- cpu_req held high continuously with cpu_adr changing mid-cycle:
  - One access per 4+W cycles, each using the address captured in IDLE.
  - One IDLE cycle between every pair of accesses.
